// File: rtl/txe_preamble_gen_pkg.sv
// Ethernet framing constants shared by the TX preamble generator and the RX preamble stripper.
package txe_preamble_gen_pkg;

  localparam logic [7:0] PREAMBLE_BYTE        = 8'h55;
  localparam logic [7:0] SFD_BYTE             = 8'hD5;
  localparam int         PREAMBLE_LEN_DEFAULT = 7;
  localparam int         IFG_LEN_DEFAULT      = 12;

endpackage

// File: rtl/txe_preamble_gen.sv
// TX framer: prepends PREAMBLE_LEN x 0x55 plus 0xD5 to each packet and enforces a minimum
// inter-frame gap; with i_en low it degenerates to a one-stage byte pipe.
module txe_preamble_gen
  import txe_preamble_gen_pkg::*;
#(
  parameter int PREAMBLE_LEN = PREAMBLE_LEN_DEFAULT,
  parameter int IFG_LEN      = IFG_LEN_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_ce,
  input  logic       i_en,
  input  logic       i_v,
  input  logic [7:0] i_d,
  output logic       o_busy,
  output logic       o_v,
  output logic [7:0] o_d
);

  localparam int               CNT_W    = 4 + $clog2(IFG_LEN);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN);
  localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_LEN - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_IFG} state_t;

  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic             r_v, w_v;
  logic             r_busy, w_busy;
  logic [7:0]       r_d, w_d;

  always_comb begin
    // NOTE: every next value defaults to its register first, so no path can leave one
    // unassigned and no latch is inferred.
    w_state = r_state;
    w_cnt   = r_cnt;
    w_v     = r_v;
    w_d     = r_d;
    w_busy  = r_busy;
    if (!i_en) begin
      w_state = S_IDLE;
      w_cnt   = '0;
      w_v     = i_v;
      w_d     = i_v ? i_d : 8'h00;
      w_busy  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_busy = 1'b1;
          if (i_v) begin
            w_v     = 1'b1;
            w_d     = PREAMBLE_BYTE;
            w_cnt   = CNT_ONE;
            w_state = S_PREAMBLE;
          end else begin
            w_v = 1'b0;
            w_d = 8'h00;
          end
        end
        // Preamble runs to completion even if i_v drops; DATA then closes an empty frame.
        S_PREAMBLE: begin
          w_v = 1'b1;
          if (r_cnt == PRE_LAST) begin
            w_d     = SFD_BYTE;
            w_busy  = 1'b0;
            w_state = S_DATA;
          end else begin
            w_d   = PREAMBLE_BYTE;
            w_cnt = r_cnt + CNT_ONE;
          end
        end
        S_DATA: begin
          if (i_v) begin
            w_v = 1'b1;
            w_d = i_d;
          end else begin
            w_v     = 1'b0;
            w_d     = 8'h00;
            w_busy  = 1'b1;
            w_cnt   = '0;
            w_state = S_IFG;
          end
        end
        S_IFG: begin
          w_v   = 1'b0;
          w_d   = 8'h00;
          w_cnt = r_cnt + CNT_ONE;
          if (r_cnt == IFG_LAST) w_state = S_IDLE;
        end
        default: w_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_v     <= 1'b0;
      r_d     <= 8'h00;
      r_busy  <= 1'b1;
    end else if (i_ce) begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_v     <= w_v;
      r_d     <= w_d;
      r_busy  <= w_busy;
    end
  end

  assign o_v    = r_v;
  assign o_d    = r_d;
  assign o_busy = r_busy;

`ifdef FORMAL
  a_od_zero: assert property (@(posedge i_clk) !r_v |-> (r_d == 8'h00));
  a_preamble: assert property (@(posedge i_clk)
    (r_state == S_PREAMBLE) |-> (r_v && r_d == PREAMBLE_BYTE));
  a_sfd: assert property (@(posedge i_clk) disable iff (i_reset)
    (r_state == S_PREAMBLE && r_cnt == PRE_LAST && i_ce && i_en) |=> (r_v && r_d == SFD_BYTE));
  a_ifg_bound: assert property (@(posedge i_clk) (r_state == S_IFG) |-> (r_cnt <= IFG_LAST));
  a_bypass: assert property (@(posedge i_clk) disable iff (i_reset)
    (i_ce && !i_en) |=> (r_v == $past(i_v) && !r_busy &&
                         r_d == ($past(i_v) ? $past(i_d) : 8'h00)));
`endif

endmodule
